// File: rtl/interleaver.sv
// interleaver
//   Transmit-side block interleaver. Serial bits are written row-wise into a
//   ROWS x COLS block; once the block is full it is read out column-wise as
//   SYM_W-bit symbols, with the earliest-read bit in the MSB. The output
//   matches the deinterleaver's in_bits/data_ready format, so chaining the two
//   with the same parameters restores the original bit order.
//
// Ports
//   clk        : rising-edge clock
//   reset      : asynchronous, active-high reset
//   data_valid : data_in carries a bit this cycle
//   data_in    : serial input bit
//   in_ready   : block accepts a bit this cycle (registered)
//   out_bits   : interleaved symbol, bit SYM_W-1 is the earliest-read bit
//   out_valid  : out_bits is valid (no backpressure downstream)
//   block_done : one-cycle pulse alongside the last symbol of a block
//   overflow   : one-cycle pulse after data_valid was seen with in_ready low
module interleaver #(
  parameter int ROWS  = 16,
  parameter int COLS  = 8,
  parameter int SYM_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_valid,
  input  logic             data_in,
  output logic             in_ready,
  output logic [SYM_W-1:0] out_bits,
  output logic             out_valid,
  output logic             block_done,
  output logic             overflow
);

  localparam int N    = ROWS * COLS;
  localparam int NSYM = N / SYM_W;
  localparam int AW   = $clog2(N);
  localparam int RW   = $clog2(NSYM);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t           state, state_next;
  logic [AW-1:0]    wr_cnt, wr_cnt_next;
  logic [RW-1:0]    rd_cnt, rd_cnt_next;
  logic             in_ready_next, out_valid_next, block_done_next, overflow_next;
  logic [SYM_W-1:0] out_bits_next;
  logic [N-1:0]     mem;
  logic             accept;
  logic [SYM_W-1:0] sym;
  logic [AW-1:0]    rd_addr;
  int               j_idx;

  // A bit is only taken while filling and after in_ready has come up, so
  // data arriving in the first cycle after reset is dropped.
  assign accept = (state == FILL) && in_ready && data_valid;

  // Block storage; bit k of a block lives at flat address k (row k/COLS,
  // col k%COLS). Contents survive reset because every block fully
  // overwrites them before any read.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_cnt] <= data_in;
  end

  // Gather symbol rd_cnt: read index j walks down a column (row j%ROWS,
  // col j/ROWS). Shifting left makes the first gathered bit the MSB.
  always_comb begin
    sym     = '0;
    j_idx   = 0;
    rd_addr = '0;
    for (int i = 0; i < SYM_W; i++) begin
      j_idx   = int'(rd_cnt) * SYM_W + i;
      rd_addr = AW'((j_idx % ROWS) * COLS + j_idx / ROWS);
      sym     = {sym[SYM_W-2:0], mem[rd_addr]};
    end
  end

  // Next-state and registered-output logic. On the cycle that emits the last
  // symbol the FSM returns to FILL with in_ready still low; in_ready then
  // rises at the edge that drops out_valid.
  always_comb begin
    state_next      = state;
    wr_cnt_next     = wr_cnt;
    rd_cnt_next     = rd_cnt;
    in_ready_next   = in_ready;
    out_valid_next  = 1'b0;
    out_bits_next   = out_bits;
    block_done_next = 1'b0;
    overflow_next   = data_valid && !in_ready;
    case (state)
      FILL: begin
        in_ready_next = 1'b1;
        if (accept) begin
          if (wr_cnt == AW'(N - 1)) begin
            wr_cnt_next   = '0;
            state_next    = DRAIN;
            in_ready_next = 1'b0;
          end else begin
            wr_cnt_next = wr_cnt + AW'(1);
          end
        end
      end
      DRAIN: begin
        in_ready_next  = 1'b0;
        out_valid_next = 1'b1;
        out_bits_next  = sym;
        if (rd_cnt == RW'(NSYM - 1)) begin
          rd_cnt_next     = '0;
          block_done_next = 1'b1;
          state_next      = FILL;
        end else begin
          rd_cnt_next = rd_cnt + RW'(1);
        end
      end
      default: state_next = FILL;
    endcase
  end

  // State and output registers; reset abandons any partial block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= FILL;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_bits   <= '0;
      block_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_next;
      wr_cnt     <= wr_cnt_next;
      rd_cnt     <= rd_cnt_next;
      in_ready   <= in_ready_next;
      out_valid  <= out_valid_next;
      out_bits   <= out_bits_next;
      block_done <= block_done_next;
      overflow   <= overflow_next;
    end
  end

endmodule

// File: tb/tb_interleaver.sv
// tb_interleaver
//   Scoreboard bench for the interleaver: expected symbols are queued as a
//   block is driven and compared as the DUT emits them.
module tb_interleaver;

  localparam int ROWS  = 16;
  localparam int COLS  = 8;
  localparam int SYM_W = 4;
  localparam int N     = ROWS * COLS;
  localparam int NSYM  = N / SYM_W;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             data_valid = 1'b0;
  logic             data_in = 1'b0;
  logic             in_ready;
  logic [SYM_W-1:0] out_bits;
  logic             out_valid;
  logic             block_done;
  logic             overflow;

  int tests_run    = 0;
  int tests_failed = 0;

  // Entries are {block_done, symbol}.
  logic [SYM_W:0]   exp_q[$];
  logic [SYM_W-1:0] rx_q[$];
  bit               record = 1'b0;
  logic [SYM_W-1:0] last_sym = '0;

  interleaver #(.ROWS(ROWS), .COLS(COLS), .SYM_W(SYM_W)) dut (
    .clk(clk),
    .reset(reset),
    .data_valid(data_valid),
    .data_in(data_in),
    .in_ready(in_ready),
    .out_bits(out_bits),
    .out_valid(out_valid),
    .block_done(block_done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Output monitor: every valid symbol must match the head of the scoreboard.
  always @(negedge clk) begin : monitor
    logic [SYM_W:0] e;
    if (!reset && out_valid) begin
      if (record) rx_q.push_back(out_bits);
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL unexpected_symbol got=%h done=%b required=no output", out_bits, block_done);
      end else begin
        e = exp_q.pop_front();
        if ({block_done, out_bits} !== e)
          begin
            tests_failed++;
            $display("[TB] FAIL symbol got done=%b bits=%h required done=%b bits=%h",
                     block_done, out_bits, e[SYM_W], e[SYM_W-1:0]);
          end
      end
    end else if (!reset && block_done) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL stray_block_done got=1 required=0");
    end
  end

  // Expected symbols derived from the write side: bit k sits at row k/COLS,
  // col k%COLS, so it is read at index col*ROWS+row.
  task automatic push_model(input logic [N-1:0] blk);
    logic [SYM_W-1:0] syms[NSYM];
    int row, col, j;
    for (int s = 0; s < NSYM; s++) syms[s] = '0;
    for (int k = 0; k < N; k++) begin
      row = k / COLS;
      col = k % COLS;
      j   = col * ROWS + row;
      syms[j / SYM_W][SYM_W - 1 - (j % SYM_W)] = blk[k];
    end
    for (int s = 0; s < NSYM; s++) exp_q.push_back({(s == NSYM - 1), syms[s]});
    last_sym = syms[NSYM-1];
  endtask

  task automatic push_const(input int idx, input logic [SYM_W-1:0] val);
    for (int s = 0; s < NSYM; s++)
      exp_q.push_back({(s == NSYM - 1), (s == idx) ? val : {SYM_W{1'b0}}});
    last_sym = (idx == NSYM - 1) ? val : '0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (in_ready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL wait_ready got=%b required=1", in_ready);
    end
  endtask

  // Drives one block starting at a negedge; returns at the negedge after the
  // edge that accepts the last bit.
  task automatic send_block(input logic [N-1:0] blk, input bit gaps, input int nbits);
    for (int k = 0; k < nbits; k++) begin
      if (gaps) begin
        while ($urandom_range(3) == 0) begin
          data_valid = 1'b0;
          @(negedge clk);
        end
      end
      data_valid = 1'b1;
      data_in    = blk[k];
      @(negedge clk);
    end
    data_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL drain_timeout got=%0d pending required=0", exp_q.size());
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++;
    if ({in_ready, out_valid, out_bits, block_done, overflow} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs got=%b required=0",
               {in_ready, out_valid, out_bits, block_done, overflow});
    end
    @(posedge clk);
    #1 reset = 1'b0;
    data_valid = 1'b1;
    data_in    = 1'b1;
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL first_cycle_in_ready got=%b required=0", in_ready);
    end
    @(posedge clk);
    #1 data_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1 || overflow !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL post_reset got in_ready=%b overflow=%b required 1 1", in_ready, overflow);
    end
    @(negedge clk);
    tests_run++;
    if (overflow !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL overflow_pulse_width got=%b required=0", overflow);
    end
  endtask

  task automatic test_impulse();
    logic [N-1:0] blk = '0;
    blk[0] = 1'b1;
    wait_ready();
    push_const(0, 4'h8);
    send_block(blk, 1'b0, N);
    wait_drain();
  endtask

  task automatic test_single_bits();
    logic [N-1:0] blk = '0;
    blk[1] = 1'b1;
    wait_ready();
    push_const(4, 4'h8);
    send_block(blk, 1'b0, N);
    wait_drain();
    blk = '0;
    blk[8] = 1'b1;
    wait_ready();
    push_const(0, 4'h4);
    send_block(blk, 1'b0, N);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] blk = {$urandom, $urandom, $urandom, $urandom};
    int bad = 0;
    wait_ready();
    push_model(blk);
    send_block(blk, 1'b0, N);
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL latency_gap got out_valid=%b in_ready=%b required 0 0", out_valid, in_ready);
    end
    for (int c = 0; c < NSYM; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL drain_window got=%0d bad cycles required=0", bad);
    end
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL drain_end got out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
    tests_run++;
    if (out_bits !== last_sym) begin
      tests_failed++;
      $display("[TB] FAIL out_bits_hold got=%h required=%h", out_bits, last_sym);
    end
  endtask

  task automatic test_gaps_overflow();
    logic [N-1:0] blk = {$urandom, $urandom, $urandom, $urandom};
    wait_ready();
    push_model(blk);
    send_block(blk, 1'b1, N);
    data_valid = 1'b1;
    data_in    = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    tests_run++;
    if (overflow !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL overflow_in_drain got=%b required=1", overflow);
    end
    @(negedge clk);
    tests_run++;
    if (overflow !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL overflow_clear got=%b required=0", overflow);
    end
    wait_drain();
    blk = {$urandom, $urandom, $urandom, $urandom};
    wait_ready();
    push_model(blk);
    send_block(blk, 1'b1, N);
    wait_drain();
  endtask

  task automatic test_reset_abort();
    logic [N-1:0] blk = '1;
    wait_ready();
    send_block(blk, 1'b0, 60);
    reset = 1'b1;
    #1;
    tests_run++;
    if ({in_ready, out_valid, out_bits, block_done, overflow} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL abort_reset_outputs got=%b required=0",
               {in_ready, out_valid, out_bits, block_done, overflow});
    end
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    blk = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    wait_ready();
    push_model(blk);
    send_block(blk, 1'b0, N);
    wait_drain();
  endtask

  // The received symbols go through a deinterleaver model; its serial output
  // must reproduce the transmitted bits in order.
  task automatic test_round_trip();
    logic [N-1:0]     v = 128'h3C3C_C3C3_CCCC_3333_C5AC_368C_0DDE_3EFC;
    logic [N-1:0]     rebuilt;
    logic [SYM_W-1:0] sym;
    int               j;
    rx_q.delete();
    record = 1'b1;
    for (int b = 0; b < 2; b++) begin
      wait_ready();
      push_model(v);
      send_block(v, 1'b1, N);
    end
    wait_drain();
    record = 1'b0;
    tests_run++;
    if (rx_q.size() != 2 * NSYM) begin
      tests_failed++;
      $display("[TB] FAIL round_trip_count got=%0d required=%0d", rx_q.size(), 2 * NSYM);
    end else begin
      for (int b = 0; b < 2; b++) begin
        rebuilt = '0;
        for (int s = 0; s < NSYM; s++) begin
          sym = rx_q.pop_front();
          for (int i = 0; i < SYM_W; i++) begin
            j = s * SYM_W + i;
            rebuilt[(j % ROWS) * COLS + j / ROWS] = sym[SYM_W - 1 - i];
          end
        end
        tests_run++;
        if (rebuilt !== v) begin
          tests_failed++;
          $display("[TB] FAIL round_trip_block%0d got=%h required=%h", b, rebuilt, v);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_single_bits();
    test_back_to_back();
    test_gaps_overflow();
    test_reset_abort();
    test_round_trip();
    repeat (5) @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL leftover_expected got=%0d required=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
